// File: rtl/bus_arbiter_pkg.sv
// bus_arbiter_pkg: state/owner encodings and default timeout for the bus arbiter
package bus_arbiter_pkg;
  typedef enum logic [1:0] {BUS_ST_IDLE, BUS_ST_IF_ACC, BUS_ST_MEM_ACC, BUS_ST_DONE} bus_st_e;
  typedef enum logic {BUS_OWNER_IF, BUS_OWNER_MEM} bus_owner_e;
  localparam int BUS_TIMEOUT_DEFAULT = 255;
endpackage

// File: rtl/bus_arbiter_timeout_cnt.sv
// bus_arbiter_timeout_cnt: strobe-length counter flagging the last allowed strobe cycle
module bus_arbiter_timeout_cnt
  import bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT = BUS_TIMEOUT_DEFAULT,
  parameter int CNT_W   = 8
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = clr ? '0 : en ? cnt_q + CNT_W'(1) : cnt_q;
  always_ff @(posedge clk) cnt_q <= reset ? '0 : cnt_d;
  assign expired = cnt_q == CNT_W'(TIMEOUT - 1);
endmodule

// File: rtl/bus_arbiter.sv
// bus_arbiter: shares the external memory bus between IF and MEM with strobe/ready handshake and timeout
module bus_arbiter
  import bus_arbiter_pkg::*;
#(
  parameter int ADDR_W  = 30,
  parameter int DATA_W  = 32,
  parameter int TIMEOUT = BUS_TIMEOUT_DEFAULT,
  parameter int CNT_W   = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rd_data,
  output logic              if_ready,
  output logic              if_err,
  output logic              if_busy,
  input  logic              mem_req,
  input  logic              mem_rw,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_wr_data,
  output logic [DATA_W-1:0] mem_rd_data,
  output logic              mem_ready,
  output logic              mem_err,
  output logic              mem_busy,
  output logic              bus_as_,
  output logic              bus_rw,
  output logic [ADDR_W-1:0] bus_addr,
  output logic [DATA_W-1:0] bus_wr_data,
  input  logic [DATA_W-1:0] bus_rd_data,
  input  logic              bus_rdy_
);
  bus_st_e st_q, st_d;
  bus_owner_e owner_q, owner_d;
  logic as_q, as_d, rw_q, rw_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wd_q, wd_d, if_rd_q, if_rd_d, mem_rd_q, mem_rd_d, rd_val;
  logic if_rdy_q, if_rdy_d, mem_rdy_q, mem_rdy_d, if_err_q, if_err_d, mem_err_q, mem_err_d;
  logic in_acc, expired;
  assign in_acc = st_q == BUS_ST_IF_ACC || st_q == BUS_ST_MEM_ACC;
  assign rd_val = (bus_rdy_ || rw_q) ? '0 : bus_rd_data;
  bus_arbiter_timeout_cnt #(.TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) u_cnt (
    .clk(clk), .reset(reset), .clr(!in_acc), .en(in_acc), .expired(expired)
  );
  always_comb begin
    st_d = st_q;
    owner_d = owner_q;
    as_d = as_q;
    rw_d = rw_q;
    addr_d = addr_q;
    wd_d = wd_q;
    if_rd_d = if_rd_q;
    mem_rd_d = mem_rd_q;
    if_rdy_d = 1'b0;
    mem_rdy_d = 1'b0;
    if_err_d = 1'b0;
    mem_err_d = 1'b0;
    case (st_q)
      BUS_ST_IDLE: begin
        if (mem_req || if_req) begin
          st_d = mem_req ? BUS_ST_MEM_ACC : BUS_ST_IF_ACC;
          owner_d = mem_req ? BUS_OWNER_MEM : BUS_OWNER_IF;
          as_d = 1'b0;
          rw_d = mem_req & mem_rw;
          addr_d = mem_req ? mem_addr : if_addr;
          wd_d = mem_req ? mem_wr_data : '0;
        end
      end
      BUS_ST_IF_ACC, BUS_ST_MEM_ACC: begin
        if (!bus_rdy_ || expired) begin
          st_d = BUS_ST_DONE;
          as_d = 1'b1;
          if (owner_q == BUS_OWNER_MEM) begin
            mem_rdy_d = 1'b1;
            mem_err_d = bus_rdy_;
            mem_rd_d = rd_val;
          end else begin
            if_rdy_d = 1'b1;
            if_err_d = bus_rdy_;
            if_rd_d = rd_val;
          end
        end
      end
      default: st_d = BUS_ST_IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      st_q <= BUS_ST_IDLE;
      owner_q <= BUS_OWNER_IF;
      as_q <= 1'b1;
      rw_q <= 1'b0;
      addr_q <= '0;
      wd_q <= '0;
      if_rd_q <= '0;
      mem_rd_q <= '0;
      if_rdy_q <= 1'b0;
      mem_rdy_q <= 1'b0;
      if_err_q <= 1'b0;
      mem_err_q <= 1'b0;
    end else begin
      st_q <= st_d;
      owner_q <= owner_d;
      as_q <= as_d;
      rw_q <= rw_d;
      addr_q <= addr_d;
      wd_q <= wd_d;
      if_rd_q <= if_rd_d;
      mem_rd_q <= mem_rd_d;
      if_rdy_q <= if_rdy_d;
      mem_rdy_q <= mem_rdy_d;
      if_err_q <= if_err_d;
      mem_err_q <= mem_err_d;
    end
  end
  assign bus_as_ = as_q;
  assign bus_rw = rw_q;
  assign bus_addr = addr_q;
  assign bus_wr_data = wd_q;
  assign if_rd_data = if_rd_q;
  assign mem_rd_data = mem_rd_q;
  assign if_ready = if_rdy_q;
  assign mem_ready = mem_rdy_q;
  assign if_err = if_err_q;
  assign mem_err = mem_err_q;
  assign if_busy = if_req & ~if_rdy_q;
  assign mem_busy = mem_req & ~mem_rdy_q;
endmodule

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Shares the single external memory bus between instruction fetch (IF) and data memory access (MEM).
- Sequences each access with a strobe/ready handshake and a timeout.
- Returns read data and a one-cycle completion pulse to the owning requester.
- Generates if_busy/mem_busy, which the pipeline controller ORs into its stall signal.
- Flags bus errors, which MEM turns into a bus-error exception code.

Parameters:
ADDR_W, 30, word address width (matches word-address bus)
DATA_W, 32, word data width
TIMEOUT, 255, max cycles bus_as_ stays low without bus_rdy_ before abort; legal range 1..255
CNT_W, 8, timeout counter width; must satisfy 2^CNT_W > TIMEOUT

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
if_req  in  1  IF access request; held until if_ready
if_addr  in  ADDR_W  IF word address; read only
if_rd_data  out  DATA_W  fetched word, valid while if_ready=1
if_ready  out  1  one-cycle IF completion pulse
if_err  out  1  IF timeout, coincident with if_ready
if_busy  out  1  IF request outstanding and not completing this cycle
mem_req  in  1  MEM access request; held until mem_ready
mem_rw  in  1  1=write, 0=read
mem_addr  in  ADDR_W  MEM word address
mem_wr_data  in  DATA_W  MEM write data
mem_rd_data  out  DATA_W  MEM read data, valid while mem_ready=1
mem_ready  out  1  one-cycle MEM completion pulse
mem_err  out  1  MEM timeout, coincident with mem_ready
mem_busy  out  1  MEM request outstanding and not completing this cycle
bus_as_  out  1  address strobe, active low
bus_rw  out  1  1=write
bus_addr  out  ADDR_W  bus address
bus_wr_data  out  DATA_W  bus write data
bus_rd_data  in  DATA_W  bus read data
bus_rdy_  in  1  slave ready, active low

Behaviour:
Reset:
- One clock; reset is synchronous, active-high, sampled on the rising edge of clk.
- State returns to IDLE; owner=IF; counter=0.
- bus_as_=1, bus_rw=0, bus_addr=0, bus_wr_data=0.
- if_rd_data=mem_rd_data=0; if_ready=mem_ready=if_err=mem_err=0.
- A reset mid-access drops the transaction; no ready pulse is issued.

State machine: IDLE, IF_ACC, MEM_ACC, DONE (4 states). All outputs registered except the busy flags.
- IDLE:
  - mem_req=1 -> MEM_ACC, owner=MEM. MEM has fixed priority: it is the older instruction and IF stalls anyway.
  - else if_req=1 -> IF_ACC, owner=IF.
  - On entry, latch bus_addr/bus_rw/bus_wr_data from the winner. For IF, bus_rw=0 and bus_wr_data=0. Drive bus_as_=0 and clear the counter.
- IF_ACC / MEM_ACC:
  - Sample bus_rdy_ each cycle.
  - bus_rdy_=0 -> DONE; capture bus_rd_data into the owner's rd_data (0 for writes); owner ready=1, err=0; bus_as_=1.
  - Else, if counter==TIMEOUT-1 -> DONE with owner ready=1, err=1, rd_data=0, bus_as_=1.
  - Otherwise increment the counter.
- DONE:
  - Lasts exactly one cycle, during which the ready/err pulse is visible. Requests are ignored so a held req is not re-granted.
  - Next state is IDLE; ready and err clear.
- Busy flags:
  - if_busy = if_req & ~if_ready; mem_busy = mem_req & ~mem_ready.
  - Busy is low in the DONE cycle, so the pipeline advances on that edge.
- Latency:
  - req seen in IDLE at cycle t -> bus_as_=0 at t+1.
  - Zero-wait slave (bus_rdy_=0 at t+1) -> ready at t+2, IDLE at t+3.
  - Minimum 3 cycles per access, including the turnaround.
- Timeout:
  - bus_as_ stays low for exactly TIMEOUT cycles.
  - err is pulsed only to the owner.
- Boundary cases:
  - Requester drops req mid-access (e.g. pipeline flush): the access still completes and ready pulses; the requester ignores it. The bus is never left strobed.
  - Both requests in IDLE: MEM wins; IF is served in the next IDLE if still requesting.
  - bus_rdy_ low while bus_as_ high (IDLE/DONE): ignored.
  - bus_rdy_=0 on the same cycle the counter hits TIMEOUT-1: ready wins, err=0.
  - Address and data are stable for the whole strobe, even if requester inputs change.

Decomposition:
- Shared header bus.vh: state encodings (BUS_ST_IDLE/IF_ACC/MEM_ACC/DONE, 2 bits), owner encodings BUS_OWNER_IF/BUS_OWNER_MEM, default TIMEOUT constant.
- Exception codes (bus-error ISAEXP value) belong in the ISA header; this block only emits err.
- One natural sub-module: bus_timeout_cnt. It provides clear, enable and an expired output when count==TIMEOUT-1.

Test Plan:
- Zero-wait read: if_req=1, if_addr=0x100, slave returns 0xDEADBEEF with bus_rdy_=0 on first strobe cycle -> bus_as_ low 1 cycle, if_ready pulse at t+2 with if_rd_data=0xDEADBEEF, if_busy low only at t+2.
- Simultaneous requests: if_req=mem_req=1 at same cycle, mem_rw=1, mem_addr=0x20, mem_wr_data=0x12345678 -> MEM write on bus first (bus_rw=1), mem_ready; IF strobe starts 2 cycles later.
- Wait states: slave asserts bus_rdy_ after 5 strobe cycles on MEM read -> bus_as_ low exactly 5 cycles, mem_busy high throughout, mem_ready 1 cycle, data captured.
- Timeout: TIMEOUT=4, slave never ready -> bus_as_ low exactly 4 cycles, if_ready=if_err=1 one cycle, if_rd_data=0.
- Reset mid-access: reset asserted during MEM_ACC wait -> next edge bus_as_=1, no mem_ready pulse, state IDLE; a new request afterwards completes normally.
- Held req: requester holds if_req=1 continuously -> exactly one access per 3 cycles with zero-wait slave; no double-grant in DONE cycle.
